// File: rtl/joy_db15_tx.sv
// DB15 joystick serializer: snapshots one or two 16-bit button words on the reader's LOAD strobe
// and shifts them out LSB first on JOY_CLK. Optional input glitch filter: JOY_DB15_TX_FILTER_EN.
module joy_db15_tx #(
    parameter int PLAYERS = 2,
    parameter int INVERT  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  state_dbg,
    output logic [5:0]  bit_cnt_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] FRAME_BITS = 6'(16 * PLAYERS);
    localparam logic       DATA_INV   = (INVERT != 0);

    state_t      state;
    logic [31:0] sreg;
    logic [5:0]  bit_cnt;

    logic clk_s1, clk_s2, clk_f, clk_h;
    logic load_s1, load_s2, load_f, load_h;
    logic clk_rise, load_rise;
    logic [15:0] upper_word;

    // Synchronizers idle high so a reader parked high produces no edge after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_h   <= 1'b1;
            load_s1 <= 1'b1;
            load_s2 <= 1'b1;
            load_h  <= 1'b1;
        end else begin
            clk_s1  <= JOY_CLK;
            clk_s2  <= clk_s1;
            clk_h   <= clk_f;
            load_s1 <= JOY_LOAD;
            load_s2 <= load_s1;
            load_h  <= load_f;
        end
    end

`ifdef JOY_DB15_TX_FILTER_EN
    logic clk_d, load_d;

    // Output follows only once three consecutive samples (s1, s2, d) agree.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_d  <= 1'b1;
            load_d <= 1'b1;
            clk_f  <= 1'b1;
            load_f <= 1'b1;
        end else begin
            clk_d  <= clk_s2;
            load_d <= load_s2;
            if (clk_s1 == clk_s2 && clk_s2 == clk_d)
                clk_f <= clk_s2;
            if (load_s1 == load_s2 && load_s2 == load_d)
                load_f <= load_s2;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_f  <= 1'b1;
            load_f <= 1'b1;
        end else begin
            clk_f  <= clk_s2;
            load_f <= load_s2;
        end
    end
`endif

    assign clk_rise   = clk_f & ~clk_h;
    assign load_rise  = load_f & ~load_h;
    assign upper_word = (PLAYERS == 2) ? joystick2 : 16'h0000;

    // Load level has priority over every state and over a coincident shift.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sreg       <= 32'h0;
            bit_cnt    <= 6'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!load_f) begin
                state   <= ST_LOAD;
                sreg    <= {upper_word, joystick1};
                bit_cnt <= 6'd0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_LOAD: begin
                        if (load_rise) begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            sreg    <= {1'b0, sreg[31:1]};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt + 6'd1 == FRAME_BITS) begin
                                state      <= ST_DONE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Register holds not-pressed (0) everywhere outside a frame, so bit 0 is the idle level.
    assign JOY_DATA    = sreg[0] ^ DATA_INV;
    assign state_dbg   = state;
    assign bit_cnt_dbg = bit_cnt;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: table of frames plus hand-written sequences for
// latency, abort, coincident edges, glitches and reset.
module tb_joy_db15_tx;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
`ifdef JOY_DB15_TX_FILTER_EN
    localparam int LAT  = 4;
    localparam int FILT = 1;
`else
    localparam int LAT  = 3;
    localparam int FILT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        JOY_CLK = 1'b0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_DATA;
    logic [15:0] joystick1 = 16'h0;
    logic [15:0] joystick2 = 16'h0;
    logic        busy;
    logic        frame_done;
    logic [1:0]  state_dbg;
    logic [5:0]  bit_cnt_dbg;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        logic [31:0] exp_stream;
    } vec_t;

    vec_t vecs[4];

    joy_db15_tx #(.PLAYERS(2), .INVERT(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .busy       (busy),
        .frame_done (frame_done),
        .state_dbg  (state_dbg),
        .bit_cnt_dbg(bit_cnt_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1)
            fd_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_frame(input logic [15:0] j1, input logic [15:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        JOY_LOAD  = 1'b0;
        negs(10);
        JOY_LOAD  = 1'b1;
        negs(6);
    endtask

    task automatic clk_pulse(input int hi, input int lo);
        JOY_CLK = 1'b1;
        negs(hi);
        JOY_CLK = 1'b0;
        negs(lo);
    endtask

    initial begin
        logic [31:0] got;
        int fd0;
        int c0;

        vecs[0] = '{16'h0001, 16'h8000, 32'h7FFF_FFFE};
        vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[2] = '{16'hA5C3, 16'h0F1E, 32'hF0E1_5A3C};
        vecs[3] = '{16'h1234, 16'hFEDC, 32'h0123_EDCB};

        negs(4);
        reset_n = 1'b1;
        negs(1);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", 32'(JOY_DATA), 32'd1);
        check("reset_cnt", 32'(bit_cnt_dbg), 32'd0);
        check("reset_fd", 32'(fd_count), 32'd0);

        clk_pulse(4, 4);
        clk_pulse(4, 4);
        check("idle_clk_state", 32'(state_dbg), 32'(S_IDLE));
        check("idle_clk_data", 32'(JOY_DATA), 32'd1);
        check("idle_clk_cnt", 32'(bit_cnt_dbg), 32'd0);

        for (int v = 0; v < 4; v++) begin
            fd0 = fd_count;
            load_frame(vecs[v].j1, vecs[v].j2);
            check("load_busy", 32'(busy), 32'd1);
            check("load_state", 32'(state_dbg), 32'(S_SHIFT));
            got = 32'h0;
            got[0] = JOY_DATA;
            for (int i = 1; i < 32; i++) begin
                clk_pulse(4, 4);
                got[i] = JOY_DATA;
            end
            check("no_early_done", 32'(fd_count - fd0), 32'd0);
            clk_pulse(4, 4);
            check("stream", got, vecs[v].exp_stream);
            check("frame_done_once", 32'(fd_count - fd0), 32'd1);
            check("post_frame_data", 32'(JOY_DATA), 32'd1);
            check("post_frame_busy", 32'(busy), 32'd0);
            check("post_frame_state", 32'(state_dbg), 32'(S_IDLE));
        end

        // Shift latency from the first clk edge that can sample JOY_CLK high.
        load_frame(16'h0001, 16'h0000);
        check("lat_bit0", 32'(JOY_DATA), 32'd0);
        JOY_CLK = 1'b1;
        negs(LAT);
        check("lat_early", 32'(JOY_DATA), 32'd0);
        negs(1);
        check("lat_edge", 32'(JOY_DATA), 32'd1);
        JOY_CLK = 1'b0;
        negs(4);
        check("lat_cnt", 32'(bit_cnt_dbg), 32'd1);

        // Reload after 5 shifts abandons the frame.
        load_frame(16'h0021, 16'h0000);
        for (int i = 0; i < 5; i++)
            clk_pulse(4, 4);
        check("abort_bit5", 32'(JOY_DATA), 32'd0);
        check("abort_cnt5", 32'(bit_cnt_dbg), 32'd5);
        fd0 = fd_count;
        joystick1 = 16'h0000;
        JOY_LOAD = 1'b0;
        negs(6);
        check("abort_state", 32'(state_dbg), 32'(S_LOAD));
        check("abort_cnt", 32'(bit_cnt_dbg), 32'd0);
        check("abort_data", 32'(JOY_DATA), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        JOY_LOAD = 1'b1;
        negs(6);
        check("abort_shift", 32'(state_dbg), 32'(S_SHIFT));
        check("abort_no_fd", 32'(fd_count - fd0), 32'd0);

        // 40 pulses: one frame_done, extra pulses leave the idle level.
        fd0 = fd_count;
        load_frame(16'hFFFF, 16'hFFFF);
        for (int i = 1; i <= 32; i++)
            clk_pulse(4, 4);
        for (int i = 33; i <= 40; i++) begin
            clk_pulse(4, 4);
            check("extra_pulse_data", 32'(JOY_DATA), 32'd1);
        end
        check("extra_fd_once", 32'(fd_count - fd0), 32'd1);
        check("extra_cnt_sat", 32'(bit_cnt_dbg), 32'd32);
        check("extra_state", 32'(state_dbg), 32'(S_IDLE));

        // Coincident JOY_CLK rise and JOY_LOAD fall: load wins.
        load_frame(16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++)
            clk_pulse(4, 4);
        joystick1 = 16'h0001;
        JOY_CLK   = 1'b1;
        JOY_LOAD  = 1'b0;
        negs(6);
        check("coincide_state", 32'(state_dbg), 32'(S_LOAD));
        check("coincide_cnt", 32'(bit_cnt_dbg), 32'd0);
        check("coincide_data", 32'(JOY_DATA), 32'd0);
        JOY_CLK = 1'b0;
        negs(2);
        JOY_LOAD = 1'b1;
        negs(6);
        check("coincide_shift_cnt", 32'(bit_cnt_dbg), 32'd0);
        check("coincide_shift_data", 32'(JOY_DATA), 32'd0);

        // Short and long pulses: 2-clk passes only without the filter.
        c0 = int'(bit_cnt_dbg);
        clk_pulse(2, 6);
        check("glitch_2clk", 32'(bit_cnt_dbg), 32'(c0 + (FILT != 0 ? 0 : 1)));
        c0 = int'(bit_cnt_dbg);
        clk_pulse(5, 6);
        check("pulse_5clk", 32'(bit_cnt_dbg), 32'(c0 + 1));

        // Reset mid-shift for one clk.
        fd0 = fd_count;
        reset_n = 1'b0;
        negs(1);
        check("rst_mid_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data", 32'(JOY_DATA), 32'd1);
        check("rst_mid_cnt", 32'(bit_cnt_dbg), 32'd0);
        reset_n = 1'b1;
        negs(6);
        check("rst_after_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_after_no_fd", 32'(fd_count - fd0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
